// File: rtl/sdpram_pipe_pkg.sv
// Shared types and lane helpers for the sdpram_pipe buffer RAM.
// Parity support is enabled with the SDPRAM_PIPE_PARITY_EN macro.
package sdpram_pipe_pkg;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    localparam int LANE_W = 8;

    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic logic [LANE_W-1:0] lane_merge(
        input logic [LANE_W-1:0] old_b,
        input logic [LANE_W-1:0] new_b,
        input logic              en
    );
        return en ? new_b : old_b;
    endfunction

    // Even parity: the stored bit makes the lane plus parity an even count.
    function automatic logic lane_par(input logic [LANE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sdpram_pipe_rdpipe.sv
// RD_LAT-deep read result pipeline; data holds when no result arrives.
// With SDPRAM_PIPE_PARITY_EN a parity-error flag travels alongside.
module sdpram_pipe_rdpipe
    import sdpram_pipe_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
`ifdef SDPRAM_PIPE_PARITY_EN
    input  logic          err_i,
    output logic          err_o,
`endif
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [DW-1:0]     dat_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < RD_LAT; s++) dat_q[s] <= '0;
        end else begin
            vld_q[0] <= valid_i;
            if (valid_i) dat_q[0] <= data_i;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign valid_o = vld_q[RD_LAT-1];
    assign data_o  = dat_q[RD_LAT-1];

`ifdef SDPRAM_PIPE_PARITY_EN
    logic [RD_LAT-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q[0] <= valid_i & err_i;
            for (int s = 1; s < RD_LAT; s++) err_q[s] <= err_q[s-1];
        end
    end

    assign err_o = err_q[RD_LAT-1];
`endif

endmodule

// File: rtl/sdpram_pipe.sv
// Simple dual-port RAM with byte enables, read pipeline, bypass and clear.
// Define SDPRAM_PIPE_PARITY_EN for per-lane parity and error injection.
module sdpram_pipe
    import sdpram_pipe_pkg::*;
#(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            init_done,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW/8-1:0] wr_be,
    input  logic [DW-1:0]   wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic            rd_valid,
`ifdef SDPRAM_PIPE_PARITY_EN
    input  logic            wr_par_flip,
    output logic            par_err,
`endif
    output logic [DW-1:0]   rd_data
);

    localparam int DEPTH = 2 ** AW;
    localparam int BW    = DW / LANE_W;

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
        $error("sdpram_pipe: RD_LAT must be 1 or 2");
    end
    if ((DW % LANE_W) != 0) begin : g_bad_dw
        $error("sdpram_pipe: DW must be a multiple of 8");
    end

    state_e        state_q;
    logic [AW-1:0] clr_q;
    logic          init_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            clr_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == {AW{1'b1}}) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                S_RUN: state_q <= S_RUN;
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign init_done = init_done_q;

    logic run, wr_acc, rd_acc, byp;

    assign run    = (state_q == S_RUN);
    assign wr_acc = run & wr_en;
    assign rd_acc = run & rd_en;
    assign byp    = (BYPASS != 0) && wr_acc && (rd_addr == wr_addr);

    // The clear sequence owns the single write port until S_RUN.
    logic [AW-1:0] mem_wa_d;
    logic [BW-1:0] mem_be_d;
    logic [DW-1:0] mem_wd_d;

    always_comb begin
        mem_wa_d = clr_q;
        mem_be_d = '1;
        mem_wd_d = '0;
        if (run) begin
            mem_wa_d = wr_addr;
            mem_be_d = wr_acc ? wr_be : '0;
            mem_wd_d = wr_data;
        end
    end

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BW; i++) begin
            if (mem_be_d[i])
                mem_q[mem_wa_d][i*LANE_W +: LANE_W] <=
                    mem_wd_d[i*LANE_W +: LANE_W];
        end
    end

    logic [DW-1:0] rd_raw, rd_word;

    assign rd_raw = mem_q[rd_addr];

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < BW; i++) begin
            rd_word[i*LANE_W +: LANE_W] = lane_merge(
                rd_raw[i*LANE_W +: LANE_W],
                wr_data[i*LANE_W +: LANE_W],
                byp & wr_be[i]);
        end
    end

`ifdef SDPRAM_PIPE_PARITY_EN
    logic [BW-1:0] par_q [DEPTH];
    logic [BW-1:0] wr_par, mem_wp_d, rd_par_raw, rd_par, rd_calc;
    logic          rd_perr;

    always_comb begin
        wr_par  = '0;
        rd_par  = '0;
        rd_calc = '0;
        for (int i = 0; i < BW; i++) begin
            wr_par[i]  = lane_par(wr_data[i*LANE_W +: LANE_W]) ^ wr_par_flip;
            rd_par[i]  = (byp & wr_be[i]) ? wr_par[i] : rd_par_raw[i];
            rd_calc[i] = lane_par(rd_word[i*LANE_W +: LANE_W]);
        end
    end

    assign mem_wp_d   = run ? wr_par : '0;
    assign rd_par_raw = par_q[rd_addr];
    assign rd_perr    = |(rd_calc ^ rd_par);

    always_ff @(posedge clk) begin
        for (int i = 0; i < BW; i++) begin
            if (mem_be_d[i]) par_q[mem_wa_d][i] <= mem_wp_d[i];
        end
    end
`endif

    sdpram_pipe_rdpipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (rd_acc),
        .data_i  (rd_word),
`ifdef SDPRAM_PIPE_PARITY_EN
        .err_i   (rd_perr),
        .err_o   (par_err),
`endif
        .valid_o (rd_valid),
        .data_o  (rd_data)
    );

endmodule

// File: tb/tb_sdpram_pipe.sv
// Bench for sdpram_pipe: two configurations driven in lockstep against a
// word-level model; parity checks are included with SDPRAM_PIPE_PARITY_EN.
module tb_sdpram_pipe;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          flip  = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [BW-1:0] wr_be   = '0;
    logic [DW-1:0] wr_data = '0;

    logic          init_a, vld_a, init_b, vld_b;
    logic [DW-1:0] dat_a, dat_b;
`ifdef SDPRAM_PIPE_PARITY_EN
    logic          perr_a, perr_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: single-cycle read with bypass; B: two-cycle read, old data on collision.
    sdpram_pipe #(.AW(AW), .DW(DW), .RD_LAT(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .init_done(init_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(vld_a),
`ifdef SDPRAM_PIPE_PARITY_EN
        .wr_par_flip(flip), .par_err(perr_a),
`endif
        .rd_data(dat_a)
    );

    sdpram_pipe #(.AW(AW), .DW(DW), .RD_LAT(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .init_done(init_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(vld_b),
`ifdef SDPRAM_PIPE_PARITY_EN
        .wr_par_flip(flip), .par_err(perr_b),
`endif
        .rd_data(dat_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t",
                         nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } rd_t;

    logic [DW-1:0] mem_m [DEPTH];
    logic [BW-1:0] bad_m [DEPTH];
    rd_t           qa[$];
    rd_t           qb[$];
    logic [31:0]   hold_a = '0;
    logic [31:0]   hold_b = '0;
    int            n_m  = 0;
    int            ecnt = 0;

    // Model: after reset the array reads as zero once DEPTH edges have passed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_m = 0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_m[i] = '0;
                bad_m[i] = '0;
            end
            qa.delete();
            qb.delete();
            hold_a = '0;
            hold_b = '0;
        end else begin
            ecnt++;
            if (n_m >= DEPTH) begin
                if (rd_en) begin
                    rd_t ea, eb;
                    ea.d = mem_m[rd_addr];
                    ea.e = 1'b0;
                    eb.d = mem_m[rd_addr];
                    eb.e = |bad_m[rd_addr];
                    begin
                        logic [BW-1:0] nb;
                        nb = bad_m[rd_addr];
                        if (wr_en && wr_addr == rd_addr)
                            for (int i = 0; i < BW; i++)
                                if (wr_be[i]) begin
                                    ea.d[8*i +: 8] = wr_data[8*i +: 8];
                                    nb[i] = flip;
                                end
                        ea.e = |nb;
                    end
                    ea.due = ecnt;
                    eb.due = ecnt + 1;
                    qa.push_back(ea);
                    qb.push_back(eb);
                end
                if (wr_en)
                    for (int i = 0; i < BW; i++)
                        if (wr_be[i]) begin
                            mem_m[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                            bad_m[wr_addr][i] = flip;
                        end
            end
            n_m++;
        end
    end

    always @(negedge clk) begin
        logic va, vb, ea, eb;
        va = (qa.size() > 0) && (qa[0].due == ecnt);
        vb = (qb.size() > 0) && (qb[0].due == ecnt);
        ea = 1'b0;
        eb = 1'b0;
        if (va) begin
            hold_a = qa[0].d;
            ea = qa[0].e;
            void'(qa.pop_front());
        end
        if (vb) begin
            hold_b = qb[0].d;
            eb = qb[0].e;
            void'(qb.pop_front());
        end
        chk("A init_done", init_a, n_m >= DEPTH);
        chk("A rd_valid", vld_a, va);
        chk("A rd_data", dat_a, hold_a);
        chk("B init_done", init_b, n_m >= DEPTH);
        chk("B rd_valid", vld_b, vb);
        chk("B rd_data", dat_b, hold_b);
`ifdef SDPRAM_PIPE_PARITY_EN
        chk("A par_err", perr_a, ea);
        chk("B par_err", perr_b, eb);
`endif
    end

    task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] be,
                      input logic [DW-1:0] d, input logic fl = 1'b0);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d; flip = fl;
        rd_en = 1'b0;
        @(negedge clk);
        wr_en = 1'b0; flip = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wrrd(input logic [AW-1:0] a, input logic [BW-1:0] be,
                        input logic [DW-1:0] d, input logic [AW-1:0] ra,
                        input logic fl = 1'b0);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d; flip = fl;
        rd_en = 1'b1; rd_addr = ra;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flip = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_init(output int cyc);
        cyc = 0;
        while (!init_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc, cnt;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Requests held through the whole clear, including its last edge.
        wr_en = 1'b1; wr_addr = 4'd2; wr_be = '1; wr_data = '1;
        rd_en = 1'b1; rd_addr = 4'd2;
        wait_init(cyc);
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        chk("init latency", cyc, 16);

        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            @(negedge clk);
        end
        rd_en = 1'b0;
        idle(3);

        wr(4'd3, 4'hF, 32'hDEADBEEF);
        wr(4'd3, 4'h2, 32'h0000AA00);
        rd(4'd3);
        idle(2);
        chk("A byte merge", dat_a, 32'hDEADAAEF);
        chk("B byte merge", dat_b, 32'hDEADAAEF);

        wr(4'd7, 4'hF, 32'hAABBCCDD);
        wrrd(4'd7, 4'h5, 32'h11223344, 4'd7);
        idle(2);
        chk("A bypass", dat_a, 32'hAA22CC44);
        chk("B no bypass", dat_b, 32'hAABBCCDD);
        rd(4'd7);
        idle(2);
        chk("A after collision", dat_a, 32'hAA22CC44);
        chk("B after collision", dat_b, 32'hAA22CC44);

        wr(4'd7, 4'h0, 32'hFFFFFFFF);
        rd(4'd7);
        idle(2);
        chk("B be=0 no-op", dat_b, 32'hAA22CC44);

        rd(4'd9);
        wr(4'd9, 4'hF, 32'h12345678);
        idle(2);
        chk("B in-flight read", dat_b, 32'h0);
        rd(4'd9);
        idle(2);
        chk("A late write", dat_a, 32'h12345678);
        chk("B late write", dat_b, 32'h12345678);

        for (int a = 8; a < 16; a++) wr(AW'(a), 4'hF, 32'hC0DE0000 + a);
        cnt = 0;
        for (int a = 8; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            @(negedge clk);
            cnt += int'(vld_b);
        end
        rd_en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            cnt += int'(vld_b);
        end
        chk("B burst valids", cnt, 8);
        chk("B burst last", dat_b, 32'hC0DE000F);

        pulse_reset();
        repeat (9) @(negedge clk);
        pulse_reset();
        rd_en = 1'b1; rd_addr = 4'd3;
        wait_init(cyc);
        rd_en = 1'b0;
        chk("re-init latency", cyc, 16);

        wr(4'd4, 4'hF, 32'h00000055);
        rd(4'd4);
        idle(2);
        chk("A post-reset write", dat_a, 32'h00000055);
        rd(4'd3);
        idle(2);
        chk("A addr3 cleared", dat_a, 32'h0);
        chk("B addr3 cleared", dat_b, 32'h0);
        rd(4'd4);
        rd(4'd7);
        idle(2);
        chk("B addr7 cleared", dat_b, 32'h0);

`ifdef SDPRAM_PIPE_PARITY_EN
        wr(4'd5, 4'h1, 32'h000000A5, 1'b1);
        rd(4'd5);
        chk("A flip valid", vld_a, 1'b1);
        chk("A flip par_err", perr_a, 1'b1);
        idle(2);
        wrrd(4'd5, 4'h1, 32'h0000003C, 4'd5, 1'b1);
        idle(2);
        wr(4'd5, 4'hF, 32'h000000A5);
        rd(4'd5);
        chk("A clean par_err", perr_a, 1'b0);
        idle(2);
`endif

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
